// File: rtl/trace_ctrl_pkg.sv
// Shared types and helpers for the instruction-trace filter controller.
package trace_ctrl_pkg;

   localparam int unsigned TRACE_PC_W    = 64;
   localparam int unsigned TRACE_INSTR_W = 32;

   typedef enum logic [1:0] {
      TRACE_IDLE    = 2'd0,
      TRACE_ARMED   = 2'd1,
      TRACE_TRACING = 2'd2,
      TRACE_STOPPED = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic [TRACE_PC_W-1:0]    pc;
      logic [TRACE_INSTR_W-1:0] instr;
   } trace_item_t;

   // Saturating counter step on a 64-bit carrier; callers cast back to their width.
   function automatic logic [63:0] sat_count(input logic [63:0] cur,
                                             input logic [63:0] max_val,
                                             input logic        inc,
                                             input logic        clr);
      if (clr) return 64'd0;
      if (inc && (cur != max_val)) return cur + 64'd1;
      return cur;
   endfunction

endpackage

// File: rtl/trace_item_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module trace_item_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 96
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign level   = level_q;
   // Masked so the head reads as zero whenever nothing is buffered.
   assign rdata   = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/trace_filter_ctrl.sv
// Trace filter controller: enable/trigger FSM, filter verdict, output FIFO and statistics.
module trace_filter_ctrl
   import trace_ctrl_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 64,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [PC_WIDTH-1:0]           in_pc,
   input  logic [INSTR_WIDTH-1:0]        in_instr,
   input  logic                          filt_drop,
   input  logic                          cfg_en,
   input  logic                          cfg_use_trig,
   input  logic                          cfg_bypass,
   input  logic [PC_WIDTH-1:0]           cfg_start_pc,
   input  logic [PC_WIDTH-1:0]           cfg_stop_pc,
   input  logic                          cmd_clr_cnt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PC_WIDTH-1:0]           out_pc,
   output logic [INSTR_WIDTH-1:0]        out_instr,
   output logic [1:0]                    state,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_WIDTH-1:0]          pass_cnt,
   output logic [CNT_WIDTH-1:0]          drop_cnt,
   output logic [CNT_WIDTH-1:0]          ovf_cnt
);

   localparam int unsigned ITEM_W  = PC_WIDTH + INSTR_WIDTH;
   localparam logic [63:0] CNT_MAX = 64'({CNT_WIDTH{1'b1}});

   trace_state_e         state_q, state_d;
   logic [CNT_WIDTH-1:0] pass_q, drop_q, ovf_q;
   logic [CNT_WIDTH-1:0] pass_d, drop_d, ovf_d;
   logic                 start_hit, stop_hit, in_window;
   logic                 drop_item, fifo_push, fifo_pop, lost_item, room;
   logic                 fifo_full, fifo_empty;
   logic [ITEM_W-1:0]    fifo_rdata;

   assign start_hit = in_valid & (state_q == TRACE_ARMED) & (in_pc == cfg_start_pc);
   assign stop_hit  = in_valid & (state_q == TRACE_TRACING) & (in_pc == cfg_stop_pc);
   assign in_window = in_valid & ((state_q == TRACE_TRACING) | start_hit);

   assign fifo_pop  = out_valid & out_ready;
   assign room      = ~fifo_full | fifo_pop;
   assign drop_item = in_window & filt_drop & ~cfg_bypass;
   assign fifo_push = in_window & ~drop_item & room;
   assign lost_item = in_window & ~drop_item & ~room;

   always_comb begin
      state_d = state_q;
      if (!cfg_en) begin
         state_d = TRACE_IDLE;
      end else begin
         case (state_q)
            TRACE_IDLE:    state_d = cfg_use_trig ? TRACE_ARMED : TRACE_TRACING;
            TRACE_ARMED:   if (start_hit) state_d = TRACE_TRACING;
            TRACE_TRACING: if (stop_hit) state_d = TRACE_STOPPED;
            default:       state_d = state_q;
         endcase
      end
   end

   always_comb begin
      pass_d = CNT_WIDTH'(sat_count(64'(pass_q), CNT_MAX, fifo_push, cmd_clr_cnt));
      drop_d = CNT_WIDTH'(sat_count(64'(drop_q), CNT_MAX, drop_item, cmd_clr_cnt));
      ovf_d  = CNT_WIDTH'(sat_count(64'(ovf_q),  CNT_MAX, lost_item, cmd_clr_cnt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TRACE_IDLE;
         pass_q  <= '0;
         drop_q  <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   trace_item_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ITEM_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata ({in_pc, in_instr}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign out_valid = ~fifo_empty;
   assign out_pc    = fifo_rdata[ITEM_W-1:INSTR_WIDTH];
   assign out_instr = fifo_rdata[INSTR_WIDTH-1:0];
   assign state     = state_q;
   assign pass_cnt  = pass_q;
   assign drop_cnt  = drop_q;
   assign ovf_cnt   = ovf_q;

endmodule
